phy_tx_lanes: RTL and testbench

//  Parametrised single-clock successor of the PHY transmit path. Accepts DATA_W-bit

---
 rtl/phy_tx_lanes.sv | 175 +++++++++++++++++
 tb/tb_phy_tx_lanes.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_lanes.sv
// phy_tx_lanes: multi-lane serial transmit path.
// Accepts DATA_W-bit words through a one-entry holding register, stripes the
// bytes across LANES lanes and shifts each lane out MSB-first, one bit per clk.
// After reset every lane sends SYNC_WORDS word periods of COM. When no word is
// ready at a word boundary, a full word period of IDL is sent.
module phy_tx_lanes #(
   parameter int          DATA_W     = 32,
   parameter int          LANES      = 2,
   parameter int          SYNC_WORDS = 2,
   parameter logic [7:0]  COM        = 8'hBC,
   parameter logic [7:0]  IDL        = 8'h7C
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] input_bus,
   input  logic              valid,
   output logic              in_ready,
   output logic [LANES-1:0]  serial_o,
   output logic              active
);

   // Bytes per lane per word; a word period lasts 8*BPL clocks.
   localparam int BPL    = DATA_W / (8 * LANES);
   localparam int SLOT_W = (BPL > 1) ? $clog2(BPL) : 1;
   localparam int SYNC_W = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BPL - 1);
   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);

   // Refuse to build with a word that cannot be split evenly over the lanes.
   if ((DATA_W <= 0) || (LANES <= 0) || ((DATA_W % (8 * LANES)) != 0)) begin : g_bad_width
      $error("phy_tx_lanes: DATA_W must be a non-zero multiple of 8*LANES");
   end
   if (SYNC_WORDS < 1) begin : g_bad_sync
      $error("phy_tx_lanes: SYNC_WORDS must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [2:0]          bit_cnt;
   logic [SLOT_W-1:0]   slot;
   logic [SYNC_W-1:0]   sync_cnt;
   logic [SYNC_W-1:0]   sync_cnt_next;
   logic [DATA_W-1:0]   hold;
   logic                hold_full;
   logic                boundary;
   logic                leave;
   logic                load;
   logic [LANES-1:0]    lane_bit;

   // Last bit of the last slot: the only point where the byte source may change.
   assign boundary = (bit_cnt == 3'd7) && (slot == SLOT_LAST);
   assign in_ready = ~hold_full;

   // Next-state decision; the sync counter only advances on boundaries in SYNC.
   always_comb begin
      state_next    = state;
      sync_cnt_next = sync_cnt;
      leave         = 1'b0;
      load          = 1'b0;
      if (boundary) begin
         if (state == ST_SYNC) begin
            if (sync_cnt < SYNC_LAST) begin
               sync_cnt_next = sync_cnt + 1'b1;
            end else begin
               leave = 1'b1;
            end
         end else begin
            leave = 1'b1;
         end
         if (leave) begin
            if (hold_full) begin
               load       = 1'b1;
               state_next = ST_DATA;
            end else begin
               state_next = ST_IDLE;
            end
         end
      end
   end

   // State and sync counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_SYNC;
         sync_cnt <= '0;
      end else begin
         state    <= state_next;
         sync_cnt <= sync_cnt_next;
      end
   end

   // Bit and slot counters wrap together at the word boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         slot    <= '0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd7) begin
            slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
         end
      end
   end

   // One-entry holding register; a drain and a fill never coincide because
   // in_ready is low whenever the register is about to drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (valid && !hold_full) begin
         hold      <= input_bus;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

   // Per-lane word registers and byte source selection.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] word_q [BPL];
      logic [7:0] data_byte;
      logic [7:0] src_byte;

      // Byte k of the held word lands in lane k%LANES, slot k/LANES.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int s = 0; s < BPL; s++) begin
               word_q[s] <= '0;
            end
         end else if (load) begin
            for (int s = 0; s < BPL; s++) begin
               word_q[s] <= hold[8*(s*LANES + gi) +: 8];
            end
         end
      end

      if (BPL == 1) begin : g_one_slot
         assign data_byte = word_q[0];
      end else begin : g_multi_slot
         assign data_byte = word_q[slot];
      end

      // Byte currently being serialised on this lane.
      always_comb begin
         src_byte = IDL;
         case (state)
            ST_SYNC: src_byte = COM;
            ST_IDLE: src_byte = IDL;
            ST_DATA: src_byte = data_byte;
            default: src_byte = IDL;
         endcase
      end

      assign lane_bit[gi] = src_byte[3'd7 - bit_cnt];
   end

   // Registered serial outputs; active flags data-carrying bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         serial_o <= '0;
         active   <= 1'b0;
      end else begin
         serial_o <= lane_bit;
         active   <= (state == ST_DATA);
      end
   end

endmodule

// File: tb/tb_phy_tx_lanes.sv
// Testbench for phy_tx_lanes: scoreboard of expected words (with the word
// period they must occupy) checked by a word-period monitor, plus scenario tasks.
module tb_phy_tx_lanes;

   localparam int         DATA_W = 32;
   localparam int         LANES  = 2;
   localparam int         SW     = 2;
   localparam int         BPL    = DATA_W / (8 * LANES);
   localparam int         P      = 8 * BPL;
   localparam int         BYTES  = DATA_W / 8;
   localparam logic [7:0] COM_B  = 8'hBC;
   localparam logic [7:0] IDL_B  = 8'h7C;

   typedef struct {
      logic [DATA_W-1:0] word;
      int                period;
   } exp_t;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] input_bus;
   logic              valid;
   logic              in_ready;
   logic [LANES-1:0]  serial_o;
   logic              active;

   logic [31:0]       input_bus2;
   logic              valid2;
   logic              in_ready2;
   logic [3:0]        serial2;
   logic              active2;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t              exp_q[$];
   logic [31:0]       q6[$];
   int                run_cnt;
   int                active_clks = 0;
   int                data_periods = 0;
   int                idle_periods = 0;

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] exp_idle;
   logic              act_first;
   logic              act_bad;
   int                idx;
   int                per;
   exp_t              e;

   phy_tx_lanes #(.DATA_W(DATA_W), .LANES(LANES), .SYNC_WORDS(SW), .COM(COM_B), .IDL(IDL_B)) dut (
      .clk(clk), .reset(reset), .input_bus(input_bus), .valid(valid),
      .in_ready(in_ready), .serial_o(serial_o), .active(active)
   );

   phy_tx_lanes #(.DATA_W(32), .LANES(4), .SYNC_WORDS(2), .COM(COM_B), .IDL(IDL_B)) dut4 (
      .clk(clk), .reset(reset), .input_bus(input_bus2), .valid(valid2),
      .in_ready(in_ready2), .serial_o(serial2), .active(active2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock edges seen since reset release; edge k emits clock index k-1.
   always @(posedge clk or posedge reset) begin
      if (reset) run_cnt <= 0;
      else       run_cnt <= run_cnt + 1;
   end

   // Word-period monitor: reassembles each period and checks it against the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         acc       = '0;
         act_first = 1'b0;
         act_bad   = 1'b0;
      end else if (run_cnt > 0) begin
         idx = (run_cnt - 1) % P;
         per = (run_cnt - 1) / P;
         if (active === 1'b1) active_clks++;
         for (int l = 0; l < LANES; l++) begin
            acc[8*((idx/8)*LANES + l) + 7 - (idx%8)] = serial_o[l];
         end
         if (idx == 0) begin
            act_first = active;
            act_bad   = 1'b0;
         end else if (active !== act_first) begin
            act_bad = 1'b1;
         end
         if (idx == P - 1) begin
            n_tests++;
            if (act_bad) begin
               n_fail++;
               $display("FAIL active_steady period %0d: active changed inside period, required constant", per);
            end
            if (act_first === 1'b1) begin
               data_periods++;
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_data period %0d: got word %h, required no data", per, acc);
               end else begin
                  e = exp_q.pop_front();
                  if (acc !== e.word || per != e.period) begin
                     n_fail++;
                     $display("FAIL data_word: got %h in period %0d, required %h in period %0d",
                              acc, per, e.word, e.period);
                  end else begin
                     $display("[TB] data word %h in period %0d", acc, per);
                  end
               end
            end else begin
               idle_periods++;
               for (int b = 0; b < BYTES; b++) begin
                  exp_idle[8*b +: 8] = (per < SW) ? COM_B : IDL_B;
               end
               n_tests++;
               if (acc !== exp_idle) begin
                  n_fail++;
                  $display("FAIL idle_word period %0d: got %h, required %h", per, acc, exp_idle);
               end
            end
         end
      end
   end

   // Period a word must appear in, given run_cnt at the cycle its valid was driven.
   function automatic int exp_period(input int r);
      int p;
      p = r / P + 1;
      if (r % P == P - 1) p++;
      if (p < SW) p = SW;
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_phase(input int ph);
      int n;
      n = 0;
      while ((run_cnt % P != ph) && (n < 2 * P)) begin
         step();
         n++;
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      exp_q.delete();
      q6.delete();
      repeat (3) step();
      reset = 1'b0;
   endtask

   // One single-cycle transfer attempt; queues the expectation when accepted.
   task automatic send_word(input logic [DATA_W-1:0] w, input string name);
      int   r;
      logic rdy;
      input_bus = w;
      valid     = 1'b1;
      r   = run_cnt;
      rdy = in_ready;
      step();
      valid = 1'b0;
      n_tests++;
      if (rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_accept: in_ready %b, required 1", name, rdy);
      end else begin
         exp_q.push_back('{word: w, period: exp_period(r)});
         $display("[TB] %s sent %h at run_cnt %0d", name, w, r);
      end
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ready_low: in_ready %b, required 0", name, in_ready);
      end
   endtask

   task automatic test_reset();
      int idle0;
      reset = 1'b1;
      valid = 1'b0; valid2 = 1'b0;
      input_bus = '0; input_bus2 = '0;
      repeat (3) step();
      n_tests++;
      if (serial_o !== '0 || active !== 1'b0 || in_ready !== 1'b1 || serial2 !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: serial %b active %b in_ready %b serial2 %b, required 0 0 1 0",
                  serial_o, active, in_ready, serial2);
      end
      idle0 = idle_periods;
      reset = 1'b0;
      step();
      n_tests++;
      if (serial_o !== {LANES{COM_B[7]}} || active !== 1'b0) begin
         n_fail++;
         $display("FAIL first_bit: serial %b active %b, required %b 0", serial_o, active, {LANES{COM_B[7]}});
      end
      repeat (4 * P) step();
      n_tests++;
      if (idle_periods - idle0 != 4 || data_periods != 0) begin
         n_fail++;
         $display("FAIL sync_idle_count: idle %0d data %0d, required 4 0", idle_periods - idle0, data_periods);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_single_word();
      int a0, d0;
      wait_phase(5);
      a0 = active_clks; d0 = data_periods;
      send_word(32'hA1B2C3D4, "single");
      repeat (3 * P) step();
      n_tests++;
      if (active_clks - a0 != 16 || data_periods - d0 != 1) begin
         n_fail++;
         $display("FAIL single_active: active clks %0d data periods %0d, required 16 1",
                  active_clks - a0, data_periods - d0);
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] w[3];
      int   a0, r, n;
      logic rdy, done;
      w[0] = 32'h00000001; w[1] = 32'h00000002; w[2] = 32'h00000003;
      wait_phase(9);
      a0 = active_clks;
      for (int i = 0; i < 3; i++) begin
         input_bus = w[i];
         valid     = 1'b1;
         done      = 1'b0;
         n         = 0;
         while (!done && n < 3 * P) begin
            r   = run_cnt;
            rdy = in_ready;
            step();
            n++;
            if (rdy === 1'b1) begin
               done = 1'b1;
               exp_q.push_back('{word: w[i], period: exp_period(r)});
               $display("[TB] b2b word %0d accepted at run_cnt %0d", i, r);
               n_tests++;
               if (in_ready !== 1'b0) begin
                  n_fail++;
                  $display("FAIL b2b_ready_low: in_ready %b, required 0", in_ready);
               end
            end else if (in_ready === 1'b1) begin
               n_tests++;
               if (run_cnt % P != 0) begin
                  n_fail++;
                  $display("FAIL b2b_ready_rise: rose at phase %0d, required 0", run_cnt % P);
               end
            end
         end
         if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL b2b_timeout: word %0d not accepted, required acceptance", i);
         end
      end
      valid = 1'b0;
      repeat (5 * P) step();
      n_tests++;
      if (active_clks - a0 != 48) begin
         n_fail++;
         $display("FAIL b2b_active: active clks %0d, required 48", active_clks - a0);
      end
   endtask

   task automatic test_sync_preload();
      int d0;
      pulse_reset();
      d0 = data_periods;
      repeat (3) step();
      send_word(32'h5EC0DE01, "preload");
      repeat (5 * P) step();
      n_tests++;
      if (data_periods - d0 != 1) begin
         n_fail++;
         $display("FAIL preload_count: data periods %0d, required 1", data_periods - d0);
      end
   endtask

   task automatic test_reset_midword();
      int d0;
      wait_phase(2);
      send_word(32'hDEADBEEF, "discard");
      repeat (3) step();
      reset = 1'b1;
      #1;
      n_tests++;
      if (serial_o !== '0 || active !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_outputs: serial %b active %b in_ready %b, required 0 0 1",
                  serial_o, active, in_ready);
      end
      exp_q.delete();
      repeat (2) step();
      d0 = data_periods;
      reset = 1'b0;
      repeat (5 * P) step();
      n_tests++;
      if (data_periods - d0 != 0) begin
         n_fail++;
         $display("FAIL midreset_discard: data periods %0d, required 0", data_periods - d0);
      end
   endtask

   task automatic test_four_lanes();
      logic [31:0] got, want;
      int   n;
      logic seen;
      input_bus2 = 32'h11223344;
      n_tests++;
      if (in_ready2 !== 1'b1) begin
         n_fail++;
         $display("FAIL lanes4_ready: in_ready %b, required 1", in_ready2);
      end
      q6.push_back({8'h11, 8'h22, 8'h33, 8'h44});
      valid2 = 1'b1;
      step();
      valid2 = 1'b0;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (active2 === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL lanes4_timeout: active never rose, required rise within 40 clk");
      end else begin
         got = '0;
         for (int b = 0; b < 8; b++) begin
            if (b > 0) @(negedge clk);
            for (int l = 0; l < 4; l++) got[8*l + 7 - b] = serial2[l];
            n_tests++;
            if (active2 !== 1'b1) begin
               n_fail++;
               $display("FAIL lanes4_active bit %0d: active %b, required 1", b, active2);
            end
         end
         want = q6.pop_front();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL lanes4_bytes: got %h, required %h", got, want);
         end else begin
            $display("[TB] four-lane word %h", got);
         end
         @(negedge clk);
         n_tests++;
         if (active2 !== 1'b0 || serial2 !== {4{IDL_B[7]}}) begin
            n_fail++;
            $display("FAIL lanes4_after: active %b serial %b, required 0 %b", active2, serial2, {4{IDL_B[7]}});
         end
      end
      step();
   endtask

   initial begin
      reset = 1'b1;
      valid = 1'b0; valid2 = 1'b0;
      input_bus = '0; input_bus2 = '0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_sync_preload();
      test_reset_midword();
      test_four_lanes();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d words outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
